// File: rtl/imem_loader_if.sv
// Stream-in and memory-write bus of the instruction-memory boot loader.
// The slave modport is the loader side; the master modport is the source/memory side.
interface imem_loader_if #(
    parameter int ADDR_W = 16
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;

    modport slave (
        input  in_data, in_valid,
        output in_ready, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output in_data, in_valid,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time loader: parses an address/count/payload/checksum frame and writes the
// payload bytewise into instruction memory while holding the core stalled.
module imem_loader #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    imem_loader_if.slave  bus,
    output logic          cpu_hold,
    output logic          done,
    output logic          err
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADDR_HI = 3'd1,
        S_ADDR_LO = 3'd2,
        S_CNT_HI  = 3'd3,
        S_CNT_LO  = 3'd4,
        S_DATA    = 3'd5,
        S_CHK     = 3'd6
    } state_t;

    // Running checksum is a plain XOR fold of payload bytes.
    function automatic logic [7:0] chk_fold(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        cnt_hi_q, cnt_hi_d;
    logic [CNT_W:0]    rem_q, rem_d;
    logic [7:0]        chk_q, chk_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              in_ready_q, in_ready_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              accept_s;
    logic [CNT_W-1:0]  n_s;

    assign accept_s      = bus.in_valid && in_ready_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign cpu_hold      = cpu_hold_q;
    assign done          = done_q;
    assign err           = err_q;

    // Next-state and datapath updates for the frame parser.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_hi_d    = cnt_hi_q;
        rem_d       = rem_q;
        chk_d       = chk_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        done_d      = 1'b0;
        err_d       = err_q;
        n_s         = CNT_W'({cnt_hi_q, bus.in_data});
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ADDR_HI;
                    err_d   = 1'b0;
                    chk_d   = 8'h00;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ADDR_HI, S_ADDR_LO: begin
                if (accept_s) begin
                    addr_d  = {addr_q[ADDR_W-9:0], bus.in_data};
                    state_d = (state_q == S_ADDR_HI) ? S_ADDR_LO : S_CNT_HI;
                end else begin
                    state_d = state_q;
                end
            end
            S_CNT_HI: begin
                if (accept_s) begin
                    cnt_hi_d = bus.in_data;
                    state_d  = S_CNT_LO;
                end else begin
                    state_d = S_CNT_HI;
                end
            end
            S_CNT_LO: begin
                // Byte counter holds 2N in CNT_W+1 bits so N = all-ones still fits.
                if (accept_s) begin
                    rem_d   = {n_s, 1'b0};
                    state_d = (n_s == {CNT_W{1'b0}}) ? S_CHK : S_DATA;
                end else begin
                    state_d = S_CNT_LO;
                end
            end
            S_DATA: begin
                if (accept_s) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = bus.in_data;
                    addr_d      = addr_q + ADDR_W'(1);
                    chk_d       = chk_fold(chk_q, bus.in_data);
                    rem_d       = rem_q - (CNT_W+1)'(1);
                    state_d     = (rem_q == (CNT_W+1)'(1)) ? S_CHK : S_DATA;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_CHK: begin
                if (accept_s) begin
                    if (bus.in_data == chk_q) begin
                        done_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end else begin
                    state_d = S_CHK;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        in_ready_d = (state_d != S_IDLE);
        cpu_hold_d = (state_d != S_IDLE);
    end

    // State and output registers; reset leaves memory contents untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= {ADDR_W{1'b0}};
            cnt_hi_q    <= 8'h00;
            rem_q       <= {(CNT_W+1){1'b0}};
            chk_q       <= 8'h00;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= 8'h00;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            cpu_hold_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_hi_q    <= cnt_hi_d;
            rem_q       <= rem_d;
            chk_q       <= chk_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            done_q      <= done_d;
            err_q       <= err_d;
            in_ready_q  <= in_ready_d;
            cpu_hold_q  <= cpu_hold_d;
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frames are driven byte by byte and the write
// strobes, done/err pulses and hold signal are compared against hand-computed values.
module tb_imem_loader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic cpu_hold, done, err;

    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_W(16)) bus ();

    imem_loader #(.ADDR_W(16), .CNT_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bus      (bus.slave),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    int cmp = 0;
    int bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int both_cnt = 0;
    int we_bad = 0;
    logic acc_prev = 1'b0;
    logic [15:0] wa[$];
    logic [7:0]  wd[$];
    int          wc[$];
    logic [7:0]  fb[$];
    logic [7:0]  ed[$];

    // Record which edges carried a transfer.
    always @(posedge clk) begin
        cyc++;
        acc_prev = bus.in_valid && bus.in_ready;
    end

    // Log write strobes and result pulses away from the active edge.
    always @(negedge clk) begin
        if (bus.mem_we) begin
            wa.push_back(bus.mem_addr);
            wd.push_back(bus.mem_wdata);
            wc.push_back(cyc);
            if (!acc_prev) we_bad++;
        end
        if (done) done_cnt++;
        if (done && err) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        wc.delete();
        done_cnt = 0;
        both_cnt = 0;
        we_bad   = 0;
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send(input logic [7:0] b);
        int t;
        t = 0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) begin
            check("ready_timeout", 32'(t), 32'd0);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_fb(input bit gaps);
        foreach (fb[i]) begin
            if (gaps && i >= 4) idle($urandom_range(0, 2));
            send(fb[i]);
        end
    endtask

    task automatic check_writes(input string tag, input logic [15:0] a0);
        logic [15:0] a;
        check({tag, "_nwr"}, 32'(wa.size()), 32'(ed.size()));
        foreach (ed[i]) begin
            a = a0 + 16'(i);
            if (i < wa.size()) begin
                check({tag, "_addr"}, 32'(wa[i]), 32'(a));
                check({tag, "_data"}, 32'(wd[i]), 32'(ed[i]));
            end
        end
    endtask

    initial begin
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        idle(3);
        check("rst_outs", {bus.in_ready, bus.mem_we, cpu_hold, done, err},      32'd0);
        check("rst_bus",  {bus.mem_addr, bus.mem_wdata},                        32'd0);
        rst_n = 1'b1;
        idle(2);
        check("idle_ready", 32'(bus.in_ready), 32'd0);

        // Basic load.
        clear_log();
        pulse_start();
        check("basic_hold", 32'(cpu_hold), 32'd1);
        fb = '{8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
        send_fb(1'b0);
        check("basic_done", {done, err, cpu_hold}, 32'h4);
        idle(2);
        ed = '{8'h12, 8'h34, 8'hAB, 8'hCD};
        check_writes("basic", 16'h0010);
        if (wc.size() == 4) check("basic_b2b", 32'(wc[3] - wc[0]), 32'd3);
        check("basic_ndone", 32'(done_cnt), 32'd1);
        check("basic_pulse", 32'(done), 32'd0);

        // Bad checksum.
        clear_log();
        pulse_start();
        fb[8] = 8'h41;
        send_fb(1'b0);
        idle(4);
        check_writes("badchk", 16'h0010);
        check("badchk_flags", {done_cnt[3:0], err, cpu_hold}, 32'h2);

        // Wrap-around; this start also clears err.
        clear_log();
        pulse_start();
        check("start_clr_err", 32'(err), 32'd0);
        fb = '{8'hFF, 8'hFF, 8'h00, 8'h01, 8'h56, 8'h78, 8'h2E};
        send_fb(1'b0);
        idle(2);
        ed = '{8'h56, 8'h78};
        check_writes("wrap", 16'hFFFF);
        check("wrap_done", {done_cnt[3:0], err}, 32'h2);

        // Zero count, good then bad checksum.
        clear_log();
        pulse_start();
        fb = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_fb(1'b0);
        idle(2);
        check("zero_nwr",  32'(wa.size()), 32'd0);
        check("zero_done", {done_cnt[3:0], err}, 32'h2);
        clear_log();
        pulse_start();
        fb[4] = 8'h01;
        send_fb(1'b0);
        idle(2);
        check("zero_bad", {done_cnt[3:0], err, cpu_hold}, 32'h2);

        // Gapped payload with a stray start mid-frame.
        clear_log();
        pulse_start();
        fb = '{8'h01, 8'h00, 8'h00, 8'h03};
        send_fb(1'b0);
        ed = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        foreach (ed[i]) begin
            idle($urandom_range(0, 2));
            if (i == 2) pulse_start();
            send(ed[i]);
        end
        idle(1);
        check("gap_hold", 32'(cpu_hold), 32'd1);
        send(8'h77);
        idle(2);
        check_writes("gap", 16'h0100);
        check("gap_we_only_after_acc", 32'(we_bad), 32'd0);
        check("gap_done", {done_cnt[3:0], err}, 32'h2);
        check("never_both", 32'(both_cnt), 32'd0);

        // Reset in the middle of the payload.
        clear_log();
        pulse_start();
        fb = '{8'h00, 8'h20, 8'h00, 8'h02, 8'hAA, 8'hBB, 8'hCC};
        send_fb(1'b0);
        check("pre_rst_we", 32'(bus.mem_we), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_outs", {bus.in_ready, bus.mem_we, cpu_hold, done, err}, 32'd0);
        check("async_rst_bus",  {bus.mem_addr, bus.mem_wdata},                   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        check("post_rst_idle", {bus.in_ready, cpu_hold}, 32'd0);
        clear_log();
        pulse_start();
        fb = '{8'h00, 8'h20, 8'h00, 8'h02, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
        send_fb(1'b0);
        idle(2);
        ed = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        check_writes("reload", 16'h0020);
        check("reload_done", {done_cnt[3:0], err, cpu_hold}, 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end
endmodule
